// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC, word-aligned ROM addressing, 2-entry buffer, redirect/flush.
// Optional stop-at-LAST_ADDR behaviour is compiled in with `define FETCH_HALT_EN.
module instr_fetch_unit #(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = 8'h00,
  parameter logic [ADDR_W-1:0] LAST_ADDR = 8'h48
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              halted
);

`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  typedef enum logic {RUN, HALT} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              infl_q, infl_d;
  logic [ADDR_W-1:0] infl_pc_q, infl_pc_d;
  logic [1:0]        count_q, count_d;
  logic [DATA_W-1:0] buf_data_q [2];
  logic [DATA_W-1:0] buf_data_d [2];
  logic [ADDR_W-1:0] buf_pc_q   [2];
  logic [ADDR_W-1:0] buf_pc_d   [2];

  logic       pop;
  logic       issue;
  logic [1:0] occ;
  logic [1:0] occ_left;
  logic [1:0] wr_idx;

  assign address     = pc_q;
  assign instr_valid = (count_q != 2'd0);
  assign instr       = buf_data_q[0];
  assign instr_pc    = buf_pc_q[0];
  assign halted      = HALT_EN && (state_q == HALT) && (count_q == 2'd0) && !infl_q;

  assign pop      = instr_valid & instr_ready;
  assign occ      = count_q + {1'b0, infl_q};
  assign occ_left = occ - {1'b0, pop};
  // Tail slot after this edge's pop has shifted the buffer.
  assign wr_idx   = count_q - {1'b0, pop};

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    infl_d    = infl_q;
    infl_pc_d = infl_pc_q;
    count_d   = count_q;
    buf_data_d = buf_data_q;
    buf_pc_d   = buf_pc_q;
    issue     = 1'b0;

    if (redirect) begin
      // A concurrent pop has already been accepted by decode; everything else is stale.
      count_d = 2'd0;
      infl_d  = 1'b0;
      pc_d    = redirect_pc & ~ADDR_W'(3);
      state_d = RUN;
    end else begin
      if (pop) begin
        buf_data_d[0] = buf_data_q[1];
        buf_pc_d[0]   = buf_pc_q[1];
      end
      if (infl_q) begin
        if (wr_idx[0]) begin
          buf_data_d[1] = rom_data;
          buf_pc_d[1]   = infl_pc_q;
        end else begin
          buf_data_d[0] = rom_data;
          buf_pc_d[0]   = infl_pc_q;
        end
      end
      count_d = occ_left;

      issue  = (state_q == RUN) && (occ_left < 2'd2);
      infl_d = issue;
      if (issue) begin
        infl_pc_d = pc_q;
        pc_d      = pc_q + ADDR_W'(4);
        if (HALT_EN && (pc_q == LAST_ADDR))
          state_d = HALT;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      infl_q     <= 1'b0;
      infl_pc_q  <= '0;
      count_q    <= 2'd0;
      buf_data_q <= '{default: '0};
      buf_pc_q   <= '{default: '0};
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      infl_q     <= infl_d;
      infl_pc_q  <= infl_pc_d;
      count_q    <= count_d;
      buf_data_q <= buf_data_d;
      buf_pc_q   <= buf_pc_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a 1-cycle-latency ROM returning {24'h0, addr}.
module tb_instr_fetch_unit;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic        instr_ready = 1'b1;
  logic [7:0]  redirect_pc = 8'h00;
  logic [7:0]  address;
  logic [7:0]  instr_pc;
  logic [31:0] rom_data = 32'h0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        halted;

  int total = 0;
  int passed = 0;
  int fails = 0;

  always #5 clock = ~clock;

  always @(posedge clock) rom_data <= {24'h0, address};

  instr_fetch_unit dut (
    .clock       (clock),
    .reset       (reset),
    .address     (address),
    .rom_data    (rom_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .halted      (halted)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_head(input string tag, input logic [7:0] pc);
    check({tag, ".valid"}, 32'(instr_valid), 32'd1);
    check({tag, ".pc"}, 32'(instr_pc), 32'(pc));
    check({tag, ".instr"}, instr, {24'h0, pc});
  endtask

  // Occupancy bound, sampled away from the active edge.
  always @(negedge clock)
    check("occ_le_2", 32'((32'(dut.count_q) + 32'(dut.infl_q)) <= 32'd2), 32'd1);

  initial begin
    reset = 1'b1;
    instr_ready = 1'b1;
    tick();
    tick();
    check("rst.address", 32'(address), 32'h00);
    check("rst.valid", 32'(instr_valid), 32'd0);
    check("rst.instr", instr, 32'h0);
    check("rst.instr_pc", 32'(instr_pc), 32'h00);
    check("rst.halted", 32'(halted), 32'd0);

    // Sequential fetch: first valid after the 2nd edge, then one per cycle.
    reset = 1'b0;
    tick();
    check("lat.edge1.valid", 32'(instr_valid), 32'd0);
    tick();
    expect_head("seq", 8'h00);
    for (int k = 1; k <= 18; k++) begin
      tick();
      expect_head("seq", 8'(4 * k));
    end
    check("seq.halted", 32'(halted), 32'd0);

    // Restart at 00 and walk to the 08 head.
    redirect = 1'b1; redirect_pc = 8'h00;
    tick();
    redirect = 1'b0;
    check("restart.flush", 32'(instr_valid), 32'd0);
    tick();
    tick();
    expect_head("restart", 8'h00);
    tick(); expect_head("restart", 8'h04);
    tick(); expect_head("restart", 8'h08);

    // Redirect while 08 is popped; target low bits dropped.
    redirect = 1'b1; redirect_pc = 8'h31;
    tick();
    redirect = 1'b0;
    check("redir.flush.valid", 32'(instr_valid), 32'd0);
    tick();
    check("redir.edge1.valid", 32'(instr_valid), 32'd0);
    tick();
    expect_head("redir.tgt", 8'h30);
    tick(); expect_head("redir.next", 8'h34);

    // Wrap-around.
    redirect = 1'b1; redirect_pc = 8'hF8;
    tick();
    redirect = 1'b0;
    tick();
    tick(); expect_head("wrap", 8'hF8);
    tick(); expect_head("wrap", 8'hFC);
    tick(); expect_head("wrap", 8'h00);
    tick(); expect_head("wrap", 8'h04);
    tick(); expect_head("wrap", 8'h08);
    tick(); expect_head("wrap", 8'h0C);
    check("stall.pre.address", 32'(address), 32'h14);

    // Stall with 0C at the head.
    instr_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tick();
      expect_head("stall", 8'h0C);
      check("stall.address", 32'(address), 32'h14);
    end
    check("stall.occ", 32'(dut.count_q) + 32'(dut.infl_q), 32'd2);
    instr_ready = 1'b1;
    tick(); expect_head("unstall", 8'h10);
    tick(); expect_head("unstall", 8'h14);

    // Reset during a stall with occupancy 2.
    instr_ready = 1'b0;
    tick();
    check("prerst.occ", 32'(dut.count_q) + 32'(dut.infl_q), 32'd2);
    reset = 1'b1;
    tick();
    check("midrst.valid", 32'(instr_valid), 32'd0);
    check("midrst.address", 32'(address), 32'h00);
    reset = 1'b0;
    instr_ready = 1'b1;
    tick();
    check("midrst.edge1.valid", 32'(instr_valid), 32'd0);
    tick(); expect_head("midrst.restart", 8'h00);
    tick(); expect_head("midrst.restart", 8'h04);

`ifdef FETCH_HALT_EN
    for (int k = 2; k <= 18; k++) begin
      tick();
      expect_head("halt.run", 8'(4 * k));
    end
    check("halt.pre.halted", 32'(halted), 32'd0);
    tick();
    check("halt.drained.valid", 32'(instr_valid), 32'd0);
    check("halt.drained.halted", 32'(halted), 32'd1);
    tick();
    tick();
    check("halt.hold.valid", 32'(instr_valid), 32'd0);
    check("halt.hold.halted", 32'(halted), 32'd1);
    redirect = 1'b1; redirect_pc = 8'h10;
    tick();
    redirect = 1'b0;
    check("halt.resume.halted", 32'(halted), 32'd0);
    tick();
    tick();
    expect_head("halt.resume", 8'h10);
`else
    for (int k = 2; k <= 19; k++) begin
      tick();
      expect_head("free.run", 8'(4 * k));
    end
    check("free.halted", 32'(halted), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
